// File: rtl/imm_seq_ctrl.sv
// imm_seq_ctrl
//   Control sequencer for the immediate-class instructions ldi, addi, andi
//   and ori. Walks the fetch (T0..T2), decode (DEC) and execute (T3..T5)
//   steps, producing one-hot-per-step datapath strobes as a Moore machine.
//   Waits in T1 for mem_ready, gives up after TMO cycles, traps unknown
//   opcodes, and can chain straight from T5 into the next T0.
//
// Ports
//   clk        rising-edge clock
//   clear      asynchronous reset, active low
//   start      request to fetch/execute one instruction at the current PC
//   ir_op      opcode field of IR, valid from the cycle after T2
//   mem_ready  memory read data valid on the MDR input
//   PCout, IncPC, MARin, Zin, Zlowout, PCin   datapath strobes
//   Read, MDRin, MDRout, IRin                 memory / IR strobes
//   Gra, Grb, Rin, BAout, Yin, Cout           register-select strobes
//   alu_op     ALU operation select, non-zero only in T4
//   busy       high in every state except IDLE
//   done       one-cycle pulse in T5
//   fault      one-cycle pulse after a read timeout or an illegal opcode
module imm_seq_ctrl #(
  parameter int              OP_W     = 5,
  parameter logic [OP_W-1:0] OPC_LDI  = 5'b00101,
  parameter logic [OP_W-1:0] OPC_ADDI = 5'b01100,
  parameter logic [OP_W-1:0] OPC_ANDI = 5'b01101,
  parameter logic [OP_W-1:0] OPC_ORI  = 5'b01110,
  parameter logic [OP_W-1:0] ALU_ADD  = 5'b00011,
  parameter logic [OP_W-1:0] ALU_AND  = 5'b00101,
  parameter logic [OP_W-1:0] ALU_OR   = 5'b00110,
  parameter int              TMO      = 8
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            start,
  input  logic [OP_W-1:0] ir_op,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            IncPC,
  output logic            MARin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            PCin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Gra,
  output logic            Grb,
  output logic            Rin,
  output logic            BAout,
  output logic            Yin,
  output logic            Cout,
  output logic [OP_W-1:0] alu_op,
  output logic            busy,
  output logic            done,
  output logic            fault
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] T0    = 4'd1;
  localparam logic [3:0] T1    = 4'd2;
  localparam logic [3:0] T2    = 4'd3;
  localparam logic [3:0] DEC   = 4'd4;
  localparam logic [3:0] T3    = 4'd5;
  localparam logic [3:0] T4    = 4'd6;
  localparam logic [3:0] T5    = 4'd7;
  localparam logic [3:0] FAULT = 4'd8;

  localparam int             CNT_W    = $clog2(TMO + 1);
  // Counter value seen in the last permitted T1 cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);

  logic [3:0]       state;
  logic [3:0]       next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [OP_W-1:0]  alu_reg;
  logic             dec_ok;
  logic [OP_W-1:0]  dec_alu;
  logic             first_t1;

  // Returns {legal, alu code}; ldi shares the add path since BAout reads R0 as zero.
  function automatic logic [OP_W:0] decode_op(input logic [OP_W-1:0] op);
    if (op == OPC_LDI || op == OPC_ADDI) return {1'b1, ALU_ADD};
    else if (op == OPC_ANDI)             return {1'b1, ALU_AND};
    else if (op == OPC_ORI)              return {1'b1, ALU_OR};
    else                                 return {1'b0, {OP_W{1'b0}}};
  endfunction

  assign {dec_ok, dec_alu} = decode_op(ir_op);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state    <= IDLE;
      wait_cnt <= '0;
      alu_reg  <= '0;
    end else begin
      state <= next_state;
      // Held at zero outside T1, so it is already clear on entry.
      if (state == T1) wait_cnt <= wait_cnt + CNT_W'(1);
      else             wait_cnt <= '0;
      if (state == DEC) alu_reg <= dec_alu;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = T0;
      T0:      next_state = T1;
      T1: begin
        if (mem_ready)                  next_state = T2;
        else if (wait_cnt == CNT_LAST)  next_state = FAULT;
      end
      T2:      next_state = DEC;
      DEC:     next_state = dec_ok ? T3 : FAULT;
      T3:      next_state = T4;
      T4:      next_state = T5;
      T5:      next_state = start ? T0 : IDLE;
      FAULT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The PC update happens once, in the first T1 cycle, however long the read waits.
  assign first_t1 = (state == T1) && (wait_cnt == '0);

  always_comb begin
    PCout   = 1'b0;
    IncPC   = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    PCin    = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Rin     = 1'b0;
    BAout   = 1'b0;
    Yin     = 1'b0;
    Cout    = 1'b0;
    alu_op  = '0;
    done    = 1'b0;
    fault   = 1'b0;
    case (state)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        Zlowout = first_t1;
        PCin    = first_t1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        Grb   = 1'b1;
        BAout = 1'b1;
        Yin   = 1'b1;
      end
      T4: begin
        Cout   = 1'b1;
        Zin    = 1'b1;
        alu_op = alu_reg;
      end
      T5: begin
        Zlowout = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
        done    = 1'b1;
      end
      FAULT:   fault = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_imm_seq_ctrl.sv
// tb_imm_seq_ctrl
//   Scoreboard bench for imm_seq_ctrl. The driver issues instructions (a
//   short fixed table followed by random ones), answers reads with
//   mem_ready after a chosen number of wait cycles, and pushes the expected
//   per-instruction outcome. A monitor accumulates what the DUT actually
//   strobed and compares when done or fault appears.
module tb_imm_seq_ctrl;

  localparam int         OP_W = 5;
  localparam logic [4:0] LDI  = 5'b00101;
  localparam logic [4:0] ADDI = 5'b01100;
  localparam logic [4:0] ANDI = 5'b01101;
  localparam logic [4:0] ORI  = 5'b01110;
  localparam logic [4:0] AADD = 5'b00011;
  localparam logic [4:0] AAND = 5'b00101;
  localparam logic [4:0] AOR  = 5'b00110;
  localparam int         TMO  = 8;
  localparam int         NTX  = 70;

  logic clk = 1'b0;
  logic clear, start, mem_ready;
  logic [OP_W-1:0] ir_op;
  logic PCout, IncPC, MARin, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin;
  logic Gra, Grb, Rin, BAout, Yin, Cout, busy, done, fault;
  logic [OP_W-1:0] alu_op;

  always #5 clk = ~clk;

  imm_seq_ctrl #(
    .OP_W(OP_W), .OPC_LDI(LDI), .OPC_ADDI(ADDI), .OPC_ANDI(ANDI), .OPC_ORI(ORI),
    .ALU_ADD(AADD), .ALU_AND(AAND), .ALU_OR(AOR), .TMO(TMO)
  ) dut (
    .clk(clk), .clear(clear), .start(start), .ir_op(ir_op), .mem_ready(mem_ready),
    .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Zin(Zin), .Zlowout(Zlowout),
    .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Gra(Gra), .Grb(Grb), .Rin(Rin), .BAout(BAout), .Yin(Yin), .Cout(Cout),
    .alu_op(alu_op), .busy(busy), .done(done), .fault(fault)
  );

  typedef struct {
    bit       is_done;
    int       lat;
    int       reads;
    int       pcin;
    int       irin;
    int       yin;
    int       rin;
    int       zin;
    logic [4:0] alu;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Outcome of one instruction from the instruction-level rules: w extra
  // wait cycles means mem_ready arrives on T1 cycle w+1.
  function automatic exp_t model(input logic [4:0] op, input int w);
    exp_t e;
    bit legal;
    legal = (op == LDI) || (op == ADDI) || (op == ANDI) || (op == ORI);
    e.pcin = 1;
    e.alu  = 5'd0;
    if (w >= TMO) begin
      e.is_done = 0; e.lat = TMO + 2; e.reads = TMO;
      e.irin = 0; e.yin = 0; e.rin = 0; e.zin = 1;
    end else if (!legal) begin
      e.is_done = 0; e.lat = w + 5; e.reads = w + 1;
      e.irin = 1; e.yin = 0; e.rin = 0; e.zin = 1;
    end else begin
      e.is_done = 1; e.lat = w + 7; e.reads = w + 1;
      e.irin = 1; e.yin = 1; e.rin = 1; e.zin = 2;
      if (op == ANDI)     e.alu = AAND;
      else if (op == ORI) e.alu = AOR;
      else                e.alu = AADD;
    end
    return e;
  endfunction

  // Monitor
  int         m_lat, m_reads, m_pcin, m_irin, m_yin, m_rin, m_zin;
  logic [4:0] m_alu;
  bit         expect_idle = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (expect_idle) begin
        chk("idle_after_fault", busy, 0);
        expect_idle = 1'b0;
      end
      chk("bus_single_driver", (PCout + Zlowout + MDRout + BAout + Cout) <= 1, 1);
      if (!Cout) chk("alu_op_outside_t4", alu_op, 0);
      if (PCout) begin
        m_lat = 1; m_reads = 0; m_pcin = 0; m_irin = 0;
        m_yin = 0; m_rin = 0; m_zin = int'(Zin); m_alu = 5'd0;
      end else if (busy) begin
        m_lat++;
        m_reads += int'(Read);
        m_pcin  += int'(PCin);
        m_irin  += int'(IRin);
        m_yin   += int'(Yin);
        m_rin   += int'(Rin);
        m_zin   += int'(Zin);
        if (Cout) m_alu = alu_op;
      end
      if (done || fault) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_vs_fault", int'(done), int'(e.is_done));
          chk("latency", m_lat, e.lat);
          chk("read_cycles", m_reads, e.reads);
          chk("pcin_cycles", m_pcin, e.pcin);
          chk("irin_cycles", m_irin, e.irin);
          chk("yin_cycles", m_yin, e.yin);
          chk("rin_cycles", m_rin, e.rin);
          chk("zin_cycles", m_zin, e.zin);
          chk("alu_op_t4", m_alu, e.alu);
        end
        if (fault) expect_idle = 1'b1;
      end
    end
  end

  function automatic int all_out();
    return int'({PCout, IncPC, MARin, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin,
                 Gra, Grb, Rin, BAout, Yin, Cout, alu_op, busy, done, fault});
  endfunction

  // Directed opening sequence, then random instructions.
  logic [4:0] tbl_op [7] = '{LDI, ANDI, 5'b11111, ORI, ORI, ADDI, ADDI};
  int         tbl_w  [7] = '{0, 3, 0, 0, 0, TMO, TMO - 1};

  initial begin
    int idx, cyc, rd_cnt, cur_wait, w, k;
    bit issue, hit;
    logic [4:0] op;
    clear = 1'b0; start = 1'b0; mem_ready = 1'b0; ir_op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_out(), 0);
    clear = 1'b1;

    // Abandon an ldi in T3 with an asynchronous reset.
    ir_op = LDI; mem_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (Yin) hit = 1'b1;
    end
    chk("reached_t3", int'(hit), 1);
    clear = 1'b0;
    #1;
    chk("async_reset_outputs", all_out(), 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_held_outputs", all_out(), 0);
    end
    clear = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_after_reset", all_out(), 0);
    end

    mon_en = 1'b1;
    idx = 0; cyc = 0; rd_cnt = 0; cur_wait = 0;
    while ((idx < NTX || busy || exp_q.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (Read) begin
        rd_cnt++;
        mem_ready = (rd_cnt == cur_wait + 1);
      end else begin
        mem_ready = 1'($urandom % 2);
      end
      issue = 1'b0;
      if (idx < NTX) begin
        if (idx < 7)        issue = (done || !busy);
        else if (done)      issue = ($urandom % 2) == 0;
        else if (!busy)     issue = ($urandom % 4) != 0;
      end
      if (issue) begin
        if (idx < 7) begin
          op = tbl_op[idx];
          w  = tbl_w[idx];
        end else begin
          k = int'($urandom % 5);
          case (k)
            0: op = LDI;
            1: op = ADDI;
            2: op = ANDI;
            3: op = ORI;
            default: op = 5'($urandom);
          endcase
          w = (($urandom % 6) == 0) ? int'($urandom_range(TMO - 1, TMO + 2))
                                    : int'($urandom_range(0, 4));
        end
        cur_wait = w; rd_cnt = 0;
        ir_op = op; start = 1'b1;
        exp_q.push_back(model(op, w));
        idx++;
      end else begin
        // start is noise while busy (ignored), except in T5 where it would chain.
        start = (busy && !done) ? 1'($urandom % 2) : 1'b0;
      end
    end
    if (cyc >= 20000) chk("run_cycle_budget", cyc, 0);
    chk("all_completions_seen", exp_q.size(), 0);
    chk("final_idle", int'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
